// File: rtl/ser_sub_pkg.sv
// Shared types and helpers for the serial-subtractor sequencer.
// The state enum, the phase count and the phase-counter width helper live here.
package ser_sub_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    SHIFT_A,
    SHIFT_B,
    DRAIN,
    DONE
  } state_e;

  // Serial phases per operation: shift A, shift B, drain.
  localparam int SER_PHASES = 3;

  // Phase counter width. It must hold 0..WIDTH, so it needs clog2(WIDTH+1) bits.
  function automatic int phase_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/ser_sub_sequencer_if.sv
// Bus bundle for ser_sub_sequencer. It carries the operand handshake, the serial-unit
// link and the result handshake.
// The master side is the environment (producer, consumer and serial unit).
// The slave side is the sequencer.
interface ser_sub_sequencer_if #(
  parameter int WIDTH = 4
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             ser_clear_b;
  logic             ser_shift;
  logic             ser_data;
  logic             ser_result;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;

  modport master (
    output in_valid, op_a, op_b, ser_result, out_ready,
    input  in_ready, ser_clear_b, ser_shift, ser_data, out_valid, result
  );

  modport slave (
    input  in_valid, op_a, op_b, ser_result, out_ready,
    output in_ready, ser_clear_b, ser_shift, ser_data, out_valid, result
  );

endinterface

// File: rtl/ser_piso.sv
// Loadable WIDTH-bit right-shift register (parallel in, serial out, LSB first).
// Load has priority over shift. A zero is shifted in at the MSB.
module ser_piso #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             lsb_o
);

  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_d;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (gi == WIDTH - 1) begin : g_msb
        assign sh_d[gi] = load_i ? din_i[gi] : (shift_i ? 1'b0 : sh_q[gi]);
      end else begin : g_lower
        assign sh_d[gi] = load_i ? din_i[gi] : (shift_i ? sh_q[gi+1] : sh_q[gi]);
      end
    end
  endgenerate

  // Shift-register state, cleared asynchronously.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign lsb_o = sh_q[0];

endmodule

// File: rtl/ser_sub_sequencer.sv
// Upstream sequencer for the serial subtractor.
// On each accepted operation it clears the serial unit, then shifts op_a and op_b into it
// LSB first. It then drains the unit, collecting its serial output into a parallel result,
// and presents that result on a valid/ready handshake.
// Optional feature macro: SER_SEQ_ABORT_EN adds an abort input that cancels a running
// operation.
module ser_sub_sequencer
  import ser_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic clk,
  input logic clear,
  ser_sub_sequencer_if.slave bus
`ifdef SER_SEQ_ABORT_EN
  ,
  input logic abort
`endif
);

  localparam int CW = phase_cnt_w(WIDTH);
  localparam logic [CW-1:0] TC = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ser_clear_b_q, ser_clear_b_d;
  logic             ser_shift_q, ser_shift_d;
  logic             ser_data_q, ser_data_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic load;
  logic a_shift;
  logic b_shift;
  logic a_bit;
  logic b_bit;

  ser_piso #(.WIDTH(WIDTH)) u_a_sh (
    .clk     (clk),
    .clear   (clear),
    .load_i  (load),
    .shift_i (a_shift),
    .din_i   (bus.op_a),
    .lsb_o   (a_bit)
  );

  ser_piso #(.WIDTH(WIDTH)) u_b_sh (
    .clk     (clk),
    .clear   (clear),
    .load_i  (load),
    .shift_i (b_shift),
    .din_i   (bus.op_b),
    .lsb_o   (b_bit)
  );

  // Next state plus next values of the registered serial/handshake outputs.
  // Each output is decoded for the cycle the FSM is about to enter.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    ser_clear_b_d = 1'b1;
    ser_shift_d   = 1'b0;
    ser_data_d    = 1'b0;
    out_valid_d   = 1'b0;
    result_d      = result_q;
    load          = 1'b0;
    a_shift       = 1'b0;
    b_shift       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          load          = 1'b1;
          state_d       = CLR;
          ser_clear_b_d = 1'b0;
        end
      end
      CLR: begin
        state_d     = SHIFT_A;
        count_d     = '0;
        ser_shift_d = 1'b1;
        ser_data_d  = a_bit;
        a_shift     = 1'b1;
      end
      SHIFT_A: begin
        ser_shift_d = 1'b1;
        if (count_q == TC) begin
          state_d    = SHIFT_B;
          count_d    = '0;
          ser_data_d = b_bit;
          b_shift    = 1'b1;
        end else begin
          count_d    = count_q + 1'b1;
          ser_data_d = a_bit;
          a_shift    = 1'b1;
        end
      end
      SHIFT_B: begin
        ser_shift_d = 1'b1;
        if (count_q == TC) begin
          state_d = DRAIN;
          count_d = '0;
        end else begin
          count_d    = count_q + 1'b1;
          ser_data_d = b_bit;
          b_shift    = 1'b1;
        end
      end
      DRAIN: begin
        result_d = {bus.ser_result, result_q[WIDTH-1:1]};
        if (count_q == TC) begin
          state_d     = DONE;
          count_d     = '0;
          out_valid_d = 1'b1;
        end else begin
          count_d     = count_q + 1'b1;
          ser_shift_d = 1'b1;
        end
      end
      DONE: begin
        out_valid_d = 1'b1;
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef SER_SEQ_ABORT_EN
    // Abort cancels the operation, clears the serial unit for one cycle and drops the
    // partial result.
    if (abort && (state_q != IDLE)) begin
      state_d       = IDLE;
      count_d       = '0;
      ser_clear_b_d = 1'b0;
      ser_shift_d   = 1'b0;
      ser_data_d    = 1'b0;
      out_valid_d   = 1'b0;
      result_d      = '0;
      load          = 1'b0;
      a_shift       = 1'b0;
      b_shift       = 1'b0;
    end
`endif
  end

  // State, counter and registered outputs, all returned to idle values by clear.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q       <= IDLE;
      count_q       <= '0;
      ser_clear_b_q <= 1'b1;
      ser_shift_q   <= 1'b0;
      ser_data_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      result_q      <= '0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      ser_clear_b_q <= ser_clear_b_d;
      ser_shift_q   <= ser_shift_d;
      ser_data_q    <= ser_data_d;
      out_valid_q   <= out_valid_d;
      result_q      <= result_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.ser_clear_b = ser_clear_b_q;
  assign bus.ser_shift   = ser_shift_q;
  assign bus.ser_data    = ser_data_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.result      = result_q;

endmodule
